// File: rtl/fsmc_sample_reader.sv
// fsmc_sample_reader: streams captured ADC samples to the MCU over the FSMC read strobe,
// one prefetched word per OE pulse, with end-of-transfer and underrun flags.
module fsmc_sample_reader #(
   parameter int DEPTH  = 10000,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 12
) (
   input  logic              clk_80mhz,
   input  logic              rst,
   input  logic              start_pulse,
   input  logic              capture_done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              FPGA_OE,
   output logic [15:0]       FSMC_D,
   output logic              DATA_READY,
   output logic              read_done,
   output logic              underrun_err
);
   typedef enum logic [2:0] {IDLE, PREFETCH, LOAD, ARMED, DONE} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   state_t      r_state, w_next;
   logic        r_oe_s1, r_oe_s2, r_oe_d;
   logic [15:0] r_out_word;
   logic        w_oe_fall, w_oe_rise, w_last, w_word_valid, w_consume;
   assign w_oe_fall    = r_oe_d & ~r_oe_s2;
   assign w_oe_rise    = ~r_oe_d & r_oe_s2;
   assign w_last       = rd_addr == LAST;
   assign w_word_valid = r_state == ARMED;
   assign w_consume    = w_word_valid && w_oe_rise;
   assign DATA_READY   = w_word_valid;
   // Raw pin gate: the MCU samples the bus directly while OE is low
   assign FSMC_D       = (!FPGA_OE && w_word_valid) ? r_out_word : 16'h0000;
   always_comb begin
      w_next = r_state;
      if (start_pulse) w_next = IDLE;
      else
         case (r_state)
            IDLE:     w_next = capture_done ? PREFETCH : IDLE;
            PREFETCH: w_next = LOAD;
            LOAD:     w_next = ARMED;
            ARMED:    w_next = w_oe_rise ? (w_last ? DONE : PREFETCH) : ARMED;
            DONE:     w_next = DONE;
            default:  w_next = IDLE;
         endcase
   end
   always_ff @(posedge clk_80mhz or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_oe_s1      <= 1'b1;
         r_oe_s2      <= 1'b1;
         r_oe_d       <= 1'b1;
         r_out_word   <= '0;
         rd_addr      <= '0;
         read_done    <= 1'b0;
         underrun_err <= 1'b0;
      end else begin
         r_state <= w_next;
         r_oe_s1 <= FPGA_OE;
         r_oe_s2 <= r_oe_s1;
         r_oe_d  <= r_oe_s2;
         // LOAD is the first cycle where rd_data reflects the advanced address
         if (r_state == LOAD) r_out_word <= {w_last, 15'(rd_data)};
         if (start_pulse) begin
            rd_addr      <= '0;
            read_done    <= 1'b0;
            underrun_err <= 1'b0;
         end else begin
            if (w_consume && !w_last) rd_addr <= rd_addr + 1'b1;
            if (w_consume && w_last) read_done <= 1'b1;
            if (w_oe_fall && !w_word_valid) underrun_err <= 1'b1;
         end
      end
   end
endmodule
